mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline boundary with valid/ready handshake, stall and flush support, and an optional skid entry.
- Carries the integer and float writeback controls, the rd address, the ALU result and the load data.
- Resolves the writeback data at the output, so the register file and forwarding logic see a single value.
- Gates write enables with valid, so bubbles never write, and counts back-pressure cycles for performance analysis.

Parameters:
- DATA_W, 32, width of result, load data and writeback data.
- RADDR_W, 5, register address width.
- SKID_EN, 1. 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- ZERO_REG_SUPPRESS, 1. 1 = integer writes to register 0 are dropped; float writes are never dropped.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all held and incoming entries
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  stage can accept an entry
- in_rd  in  RADDR_W  destination register
- in_rd_sel  in  1  rd source select, passed through
- in_result  in  DATA_W  ALU/address result
- in_read_data  in  DATA_W  load data
- in_memtoreg  in  1  1 = write back load data
- in_regwrite  in  1  integer regfile write
- in_regwrite_float  in  1  float regfile write
- out_valid  out  1  head entry valid
- out_ready  in  1  WB/regfile accepts the head entry
- out_rd  out  RADDR_W  head destination register
- out_rd_sel  out  1  head rd select
- out_wb_data  out  DATA_W  out_memtoreg ? read_data : result
- out_memtoreg  out  1  head memtoreg
- out_regwrite  out  1  valid & regwrite & ~(ZERO_REG_SUPPRESS & rd==0)
- out_regwrite_float  out  1  valid & regwrite_float
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid & ~out_ready

Behaviour:
- Reset: both entries invalid and payloads zero; out_valid=0; all write enables 0; out_wb_data=0; stall_cnt=0. With SKID_EN=1, in_ready=0 during reset and 1 in the first cycle after.
- Handshake: an input transfer happens on a cycle with in_valid & in_ready; an output transfer happens on a cycle with out_valid & out_ready.
- Latency: an entry accepted at edge N appears on the outputs after edge N. Minimum latency is 1 cycle; throughput is 1 entry per cycle.
- Ordering is strictly FIFO.
- Payload outputs are don't-care when out_valid=0. Write enables are hard 0 in that case.
- SKID_EN=1 states (reg count):
  - EMPTY: accept -> ONE.
  - ONE: accept & ~deq -> TWO; deq & ~accept -> EMPTY; accept & deq -> ONE (main reloads from input).
  - TWO: deq -> ONE (skid moves to main). Input is never accepted in TWO.
  - in_ready = state!=TWO, registered from state; no combinational path from out_ready.
- SKID_EN=0: a single entry. in_ready = ~out_valid | out_ready (combinational). Simultaneous deq and accept reloads the entry.
- Flush: highest priority after rst.
  - Next state is EMPTY.
  - An input presented in the flush cycle is discarded, even if in_ready=1.
  - A head handshaken in the flush cycle counts as delivered; the WB side samples it before the edge.
  - stall_cnt is not cleared by flush.
- stall_cnt: increments on out_valid & ~out_ready, saturates at all ones, and is cleared only by rst.
- out_wb_data is combinational from the head registers; no added latency.
- Mid-operation rst: identical to power-up reset; held entries are lost.

Decomposition:
- Shared package (riscv_pipe_pkg): the mem_wb_payload_t struct (rd, rd_sel, result, read_data, memtoreg, regwrite, regwrite_float), the state encoding (EMPTY/ONE/TWO), and the default widths.
- One natural sub-module: pipe_skid_buf, a generic valid/ready skid buffer over a packed payload. mem_wb_stage instantiates it and adds the writeback mux, the write-enable gating and the stall counter.

Test Plan:
- Streaming: out_ready=1; send 4 entries (rd=1..4, result=0x10..0x13, memtoreg=0) on consecutive cycles -> out_rd 1..4 on consecutive cycles starting 1 cycle later; out_wb_data 0x10..0x13; stall_cnt=0.
- Load select: send result=0xAAAA0000, read_data=0x12345678, memtoreg=1, regwrite=1, rd=7 -> out_wb_data=0x12345678, out_regwrite=1.
- Back-pressure (SKID_EN=1): out_ready=0; offer 3 entries -> 2 accepted, in_ready=0 while full. After 5 blocked cycles stall_cnt=5. Raise out_ready -> the entries drain in order and in_ready returns to 1 one cycle after the first dequeue.
- x0 suppression: rd=0, regwrite=1, regwrite_float=1 -> out_regwrite=0, out_regwrite_float=1; repeat with ZERO_REG_SUPPRESS=0 -> out_regwrite=1.
- Flush while full (TWO) with in_valid=1 -> next cycle out_valid=0 and in_ready=1; no write enable asserts; the discarded input never appears.
- Reset mid-stream with 2 entries held: assert rst for 1 cycle -> out_valid=0, stall_cnt=0, write enables 0; a new entry after rst passes with 1-cycle latency.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared types for the pipeline boundary registers: default widths, the
// skid-buffer occupancy encoding and the MEM/WB payload layout.
package riscv_pipe_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int RADDR_W_DEF = 5;
    localparam int CNT_W_DEF   = 16;

    // Occupancy of a two-entry skid buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    // MEM/WB payload at the default widths. mem_wb_stage builds the same
    // field order at its own parameter widths.
    typedef struct packed {
        logic [RADDR_W_DEF-1:0] rd;
        logic                   rd_sel;
        logic [DATA_W_DEF-1:0]  result;
        logic [DATA_W_DEF-1:0]  read_data;
        logic                   memtoreg;
        logic                   regwrite;
        logic                   regwrite_float;
    } mem_wb_payload_t;

    // Writeback source select at the default width.
    function automatic logic [DATA_W_DEF-1:0] wb_select(
        input logic                  memtoreg,
        input logic [DATA_W_DEF-1:0] result,
        input logic [DATA_W_DEF-1:0] read_data
    );
        return memtoreg ? read_data : result;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready buffer over a packed payload.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_EMPTY | nothing held, out_valid=0
//   ST_ONE   | head entry in main register
//   ST_TWO   | head in main, next entry parked in skid; input refused
//
// SKID_EN=1: in_ready is a flop decoded from the next state, so the input
// side never sees a combinational path from out_ready.
// SKID_EN=0: only ST_EMPTY/ST_ONE are reachable; in_ready is combinational
// and a simultaneous dequeue/accept reloads the main register.
module pipe_skid_buf
    import riscv_pipe_pkg::*;
#(
    parameter int W       = 8,
    parameter bit SKID_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_q;
    skid_state_e  state_d;
    logic [W-1:0] main_q;
    logic [W-1:0] main_d;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         deq;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign deq       = out_valid & out_ready;
    // An input offered during flush is dropped even when in_ready is high.
    assign accept    = in_valid & in_ready & ~flush;

    // Next occupancy and next head contents.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (accept && deq) begin
                    main_d = in_data;
                end else if (accept) begin
                    state_d = ST_TWO;
                end else if (deq) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (deq) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    // Occupancy and head register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    if (SKID_EN) begin : g_skid
        logic [W-1:0] skid_r;
        logic         ready_r;
        logic         load_skid;

        assign load_skid = (state_q == ST_ONE) & accept & ~deq;
        assign skid_q    = skid_r;
        assign in_ready  = ready_r;

        // Skid entry capture and registered ready (low through reset).
        always_ff @(posedge clk) begin
            if (rst) begin
                skid_r  <= '0;
                ready_r <= 1'b0;
            end else begin
                if (load_skid) begin
                    skid_r <= in_data;
                end
                ready_r <= (state_d != ST_TWO);
            end
        end
    end else begin : g_single
        assign skid_q   = '0;
        assign in_ready = (state_q == ST_EMPTY) | out_ready;
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline boundary: buffers the writeback payload, resolves the
// writeback data, gates write enables with valid and counts stall cycles.
module mem_wb_stage
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_W            = DATA_W_DEF,
    parameter int RADDR_W           = RADDR_W_DEF,
    parameter bit SKID_EN           = 1'b1,
    parameter bit ZERO_REG_SUPPRESS = 1'b1,
    parameter int CNT_W             = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_rd_sel,
    input  logic [DATA_W-1:0]  in_result,
    input  logic [DATA_W-1:0]  in_read_data,
    input  logic               in_memtoreg,
    input  logic               in_regwrite,
    input  logic               in_regwrite_float,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_rd_sel,
    output logic [DATA_W-1:0]  out_wb_data,
    output logic               out_memtoreg,
    output logic               out_regwrite,
    output logic               out_regwrite_float,
    output logic [CNT_W-1:0]   stall_cnt
);

    // Same field order as mem_wb_payload_t, sized by this instance.
    typedef struct packed {
        logic [RADDR_W-1:0] rd;
        logic               rd_sel;
        logic [DATA_W-1:0]  result;
        logic [DATA_W-1:0]  read_data;
        logic               memtoreg;
        logic               regwrite;
        logic               regwrite_float;
    } payload_t;

    localparam int PAY_W = $bits(payload_t);

    payload_t           pay_in;
    payload_t           pay_head;
    logic [PAY_W-1:0]   head_bits;
    logic               head_valid;
    logic               rd_is_zero;
    logic [CNT_W-1:0]   stall_cnt_q;

    assign pay_in.rd             = in_rd;
    assign pay_in.rd_sel         = in_rd_sel;
    assign pay_in.result         = in_result;
    assign pay_in.read_data      = in_read_data;
    assign pay_in.memtoreg       = in_memtoreg;
    assign pay_in.regwrite       = in_regwrite;
    assign pay_in.regwrite_float = in_regwrite_float;

    pipe_skid_buf #(
        .W       (PAY_W),
        .SKID_EN (SKID_EN)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (head_valid),
        .out_ready (out_ready),
        .out_data  (head_bits)
    );

    assign pay_head  = payload_t'(head_bits);
    assign out_valid = head_valid;

    // Writeback mux and enable gating straight off the head register.
    always_comb begin
        out_rd       = pay_head.rd;
        out_rd_sel   = pay_head.rd_sel;
        out_memtoreg = pay_head.memtoreg;
        out_wb_data  = pay_head.memtoreg ? pay_head.read_data : pay_head.result;
        rd_is_zero   = (pay_head.rd == '0);
        out_regwrite = head_valid & pay_head.regwrite
                       & ~(ZERO_REG_SUPPRESS & rd_is_zero);
        out_regwrite_float = head_valid & pay_head.regwrite_float;
    end

    // Saturating back-pressure counter; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (head_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
